// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/mem memory-bus arbiter: owner encoding,
// FSM states and the captured bus-request record.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_MEM   = 1'b1
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                    mode;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wstrb;
  } bus_req_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_MEM) ? OWNER_FETCH : OWNER_MEM;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_slot.sv
// One-deep request slot: captures a request pulse, presents it until the
// owning transaction completes, and flags pulses that arrive while occupied.
module req_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_en,
  input  bus_req_t req,
  input  logic     clear,
  output logic     pending,
  output bus_req_t sel,
  output logic     overrun
);

  logic     valid;
  bus_req_t held;

  // The slot stays valid while its transaction is in flight, so a new pulse
  // during that window (including the completing cycle) is an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (req_en && !valid) begin
      valid <= 1'b1;
      held  <= req;
    end
  end

  assign pending = valid | req_en;
  assign sel     = valid ? held : req;
  assign overrun = req_en & valid;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and mem request channels onto one downstream memory bus,
// one transaction at a time, round-robin on ties; routes responses back.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_en,
  input  logic              f_mode,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  input  logic [DATA_W/8-1:0] f_wstrb,
  output logic              f_resp_en,
  output logic [DATA_W-1:0] f_resp_data,
  output logic              f_resp_exc,
  input  logic              m_req_en,
  input  logic              m_mode,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W/8-1:0] m_wstrb,
  output logic              m_resp_en,
  output logic [DATA_W-1:0] m_resp_data,
  output logic              m_resp_exc,
  output logic              d_req_en,
  output logic              d_mode,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W/8-1:0] d_wstrb,
  input  logic              d_resp_en,
  input  logic [DATA_W-1:0] d_resp_data,
  input  logic              d_exc_en,
  output logic              busy,
  output logic              grant_mem,
  output logic              err_overrun
);

  state_e   state, state_nxt;
  owner_e   owner, last_grant, issue_owner;
  logic     issue, complete;
  logic     f_pending, m_pending, f_overrun, m_overrun;
  logic     f_clear, m_clear;
  bus_req_t f_in, m_in, f_sel, m_sel, issue_req;

  assign f_in = {f_mode, f_addr, f_wdata, f_wstrb};
  assign m_in = {m_mode, m_addr, m_wdata, m_wstrb};

  assign f_clear = complete && (owner == OWNER_FETCH);
  assign m_clear = complete && (owner == OWNER_MEM);

  req_slot u_f_slot (
    .clk     (clk),
    .rst     (rst),
    .req_en  (f_req_en),
    .req     (f_in),
    .clear   (f_clear),
    .pending (f_pending),
    .sel     (f_sel),
    .overrun (f_overrun)
  );

  req_slot u_m_slot (
    .clk     (clk),
    .rst     (rst),
    .req_en  (m_req_en),
    .req     (m_in),
    .clear   (m_clear),
    .pending (m_pending),
    .sel     (m_sel),
    .overrun (m_overrun)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    complete    = 1'b0;
    issue_owner = OWNER_FETCH;
    unique case (state)
      IDLE: begin
        if (f_pending || m_pending) begin
          issue     = 1'b1;
          state_nxt = WAIT;
          if (f_pending && m_pending) issue_owner = other_owner(last_grant);
          else if (m_pending)         issue_owner = OWNER_MEM;
          else                        issue_owner = OWNER_FETCH;
        end
      end
      WAIT: begin
        if (d_resp_en || d_exc_en) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_req = (issue_owner == OWNER_MEM) ? m_sel : f_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWNER_FETCH;
      last_grant  <= OWNER_MEM;
      d_req_en    <= 1'b0;
      d_mode      <= 1'b0;
      d_addr      <= '0;
      d_wdata     <= '0;
      d_wstrb     <= '0;
      f_resp_en   <= 1'b0;
      f_resp_data <= '0;
      f_resp_exc  <= 1'b0;
      m_resp_en   <= 1'b0;
      m_resp_data <= '0;
      m_resp_exc  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      d_req_en    <= issue;
      f_resp_en   <= f_clear;
      m_resp_en   <= m_clear;
      err_overrun <= err_overrun | f_overrun | m_overrun;
      if (issue) begin
        owner      <= issue_owner;
        last_grant <= issue_owner;
        d_mode     <= issue_req.mode;
        d_addr     <= issue_req.addr;
        d_wdata    <= issue_req.wdata;
        d_wstrb    <= issue_req.wstrb;
      end
      // Response data is only meaningful while the matching resp_en is high.
      if (f_clear) begin
        f_resp_data <= d_resp_data;
        f_resp_exc  <= d_exc_en;
      end
      if (m_clear) begin
        m_resp_data <= d_resp_data;
        m_resp_exc  <= d_exc_en;
      end
    end
  end

  assign busy      = (state == WAIT);
  assign grant_mem = (state == WAIT) && (owner == OWNER_MEM);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected downstream requests and
// channel responses are queued at stimulus time and checked as they appear.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_en, f_mode, m_req_en, m_mode;
  logic [31:0] f_addr, f_wdata, m_addr, m_wdata;
  logic [3:0]  f_wstrb, m_wstrb;
  logic        f_resp_en, f_resp_exc, m_resp_en, m_resp_exc;
  logic [31:0] f_resp_data, m_resp_data;
  logic        d_req_en, d_mode;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_resp_en, d_exc_en;
  logic [31:0] d_resp_data;
  logic        busy, grant_mem, err_overrun;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dreq_t;

  typedef struct {
    logic [31:0] data;
    logic        exc;
  } resp_t;

  dreq_t exp_d[$];
  resp_t exp_f[$];
  resp_t exp_m[$];
  dreq_t ed;
  resp_t er;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_req_en(f_req_en), .f_mode(f_mode), .f_addr(f_addr), .f_wdata(f_wdata), .f_wstrb(f_wstrb),
    .f_resp_en(f_resp_en), .f_resp_data(f_resp_data), .f_resp_exc(f_resp_exc),
    .m_req_en(m_req_en), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_resp_en(m_resp_en), .m_resp_data(m_resp_data), .m_resp_exc(m_resp_exc),
    .d_req_en(d_req_en), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_resp_en(d_resp_en), .d_resp_data(d_resp_data), .d_exc_en(d_exc_en),
    .busy(busy), .grant_mem(grant_mem), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit ch_mem, input bit mode, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input bit expect_issue);
    if (ch_mem) begin
      m_req_en = 1'b1; m_mode = mode; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    end else begin
      f_req_en = 1'b1; f_mode = mode; f_addr = addr; f_wdata = wdata; f_wstrb = wstrb;
    end
    if (expect_issue) exp_d.push_back('{mode, addr, wdata, wstrb});
  endtask

  task automatic clr();
    f_req_en = 1'b0; m_req_en = 1'b0;
    f_addr = '0; f_wdata = '0; f_wstrb = '0; f_mode = 1'b0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_mode = 1'b0;
  endtask

  // Completes the in-flight transaction; the response must appear next cycle on ch_mem only.
  task automatic resp(input bit ch_mem, input logic [31:0] data, input bit r, input bit e);
    d_resp_en = r; d_exc_en = e; d_resp_data = data;
    if (ch_mem) exp_m.push_back('{data, e});
    else        exp_f.push_back('{data, e});
    tick();
    d_resp_en = 1'b0; d_exc_en = 1'b0;
    check(ch_mem ? "m_resp_pulse" : "f_resp_pulse", ch_mem ? m_resp_en : f_resp_en, 1);
    check(ch_mem ? "f_resp_quiet" : "m_resp_quiet", ch_mem ? f_resp_en : m_resp_en, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (d_req_en) begin
        if (exp_d.size() == 0) check("d_req_unexpected", 1, 0);
        else begin
          ed = exp_d.pop_front();
          check("d_mode", d_mode, ed.mode);
          check("d_addr", d_addr, ed.addr);
          check("d_wdata", d_wdata, ed.wdata);
          check("d_wstrb", d_wstrb, ed.wstrb);
        end
      end
      if (f_resp_en) begin
        if (exp_f.size() == 0) check("f_resp_unexpected", 1, 0);
        else begin
          er = exp_f.pop_front();
          check("f_resp_data", f_resp_data, er.data);
          check("f_resp_exc", f_resp_exc, er.exc);
        end
      end
      if (m_resp_en) begin
        if (exp_m.size() == 0) check("m_resp_unexpected", 1, 0);
        else begin
          er = exp_m.pop_front();
          check("m_resp_data", m_resp_data, er.data);
          check("m_resp_exc", m_resp_exc, er.exc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    d_resp_en = 1'b0; d_exc_en = 1'b0; d_resp_data = '0;
    clr();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_d_req", d_req_en, 0);
    check("rst_d_addr", d_addr, 0);
    check("rst_f_resp", f_resp_en, 0);
    check("rst_m_resp", m_resp_en, 0);
    check("rst_grant", grant_mem, 0);
    check("rst_err", err_overrun, 0);
    rst = 1'b0;
    tick();

    // Single fetch read with latency checks
    req(0, 0, 32'h8000_0000, 0, 0, 1);
    tick(); clr();
    check("s1_dreq_lat", d_req_en, 1);
    check("s1_busy", busy, 1);
    check("s1_owner", grant_mem, 0);
    tick();
    check("s1_dreq_one", d_req_en, 0);
    tick(); tick();
    resp(0, 32'hDEAD_BEEF, 1, 0);
    tick();
    check("s1_resp_one", f_resp_en, 0);
    check("s1_idle", busy, 0);

    // Tie after reset: fetch first, then mem two cycles after the fetch response
    do_reset();
    req(0, 0, 32'h100, 0, 0, 1);
    req(1, 0, 32'h200, 0, 0, 1);
    tick(); clr();
    check("s2_tie1_fetch", grant_mem, 0);
    tick();
    resp(0, 32'h1111, 1, 0);
    check("s2_gap", d_req_en, 0);
    tick();
    check("s2_mem_issue", d_req_en, 1);
    check("s2_mem_owner", grant_mem, 1);
    tick();
    resp(1, 32'h2222, 1, 0);
    tick();
    req(0, 0, 32'h300, 0, 0, 1);
    tick(); clr(); tick();
    resp(0, 32'h3333, 1, 0);
    tick();
    req(1, 0, 32'h400, 0, 0, 1);
    req(0, 0, 32'h500, 0, 0, 1);
    tick(); clr();
    check("s2_tie2_mem", grant_mem, 1);
    tick();
    resp(1, 32'h4444, 1, 0);
    tick();
    check("s2_tie2_fetch_next", grant_mem, 0);
    tick();
    resp(0, 32'h5555, 1, 0);
    tick();

    // Mem write held while a fetch is in flight
    req(0, 0, 32'h2000, 0, 0, 1);
    tick(); clr(); tick();
    req(1, 1, 32'h1000, 32'h1234_5678, 4'hF, 1);
    tick(); clr();
    check("s3_hold_addr", d_addr, 32'h2000);
    check("s3_hold_owner", grant_mem, 0);
    tick();
    resp(0, 32'hAAAA, 1, 0);
    tick();
    check("s3_mem_issue", d_req_en, 1);
    tick(); tick();
    check("s3_stable_addr", d_addr, 32'h1000);
    check("s3_stable_wdata", d_wdata, 32'h1234_5678);
    check("s3_stable_wstrb", d_wstrb, 4'hF);
    check("s3_stable_mode", d_mode, 1);

    // Exception on mem, then exception+response together on fetch
    resp(1, 32'h0BAD, 0, 1);
    tick();
    check("s4_idle", busy, 0);
    req(0, 0, 32'h6000, 0, 0, 1);
    tick(); clr(); tick();
    resp(0, 32'h6666, 1, 1);
    tick();
    check("s4_single_completion", f_resp_en, 0);
    check("s4_idle2", busy, 0);
    req(0, 0, 32'h7000, 0, 0, 1);
    tick(); clr(); tick();
    resp(0, 32'h7777, 1, 0);
    tick();

    // Overrun on fetch: second pulse dropped, flag sticky until reset
    req(0, 0, 32'h3000, 0, 0, 1);
    tick(); clr();
    check("s5_no_err_yet", err_overrun, 0);
    tick();
    req(0, 0, 32'h4000, 0, 0, 0);
    tick(); clr();
    check("s5_err_set", err_overrun, 1);
    check("s5_orig_addr", d_addr, 32'h3000);
    tick();
    resp(0, 32'h3030, 1, 0);
    repeat (3) tick();
    check("s5_no_reissue", busy, 0);
    check("s5_err_sticky", err_overrun, 1);
    do_reset();
    check("s5_err_cleared", err_overrun, 0);

    // Reset mid-WAIT, then a stray downstream response
    req(1, 0, 32'h5000, 0, 0, 1);
    tick(); clr(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_busy_after_rst", busy, 0);
    d_resp_en = 1'b1; d_resp_data = 32'h9999;
    tick();
    d_resp_en = 1'b0;
    check("s6_no_m_resp", m_resp_en, 0);
    check("s6_no_f_resp", f_resp_en, 0);
    check("s6_still_idle", busy, 0);
    req(0, 0, 32'h8000, 0, 0, 1);
    tick(); clr();
    check("s6_next_issue", d_req_en, 1);
    tick();
    resp(0, 32'h8888, 1, 0);
    repeat (3) tick();

    check("exp_d_left", exp_d.size(), 0);
    check("exp_f_left", exp_f.size(), 0);
    check("exp_m_left", exp_m.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
